// File: rtl/sorted_vec_unloader.sv
// sorted_vec_unloader: serializes one descending-sorted N-element vector per handshake,
// largest element first, tagging each beat with its rank and flagging unsorted input.
`default_nettype none

module sorted_vec_unloader #(
  parameter int WIDTH = 10,
  parameter int N     = 4,
  localparam int RW   = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [RW-1:0]      out_rank,
  output logic               out_last,
  output logic               order_err,
  output logic [7:0]         err_cnt,
  input  logic               err_clear
);

  localparam logic [0:0]    IDLE      = 1'b0;
  localparam logic [0:0]    SHIFT     = 1'b1;
  localparam logic [RW-1:0] LAST_RANK = RW'(N - 1);

  logic [0:0]       state_q, state_d;
  logic [RW-1:0]    rank_q, rank_d;
  logic [WIDTH-1:0] buf_q [N];
  logic [WIDTH-1:0] buf_d [N];
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic             order_err_q, order_err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic          w_last_beat;
  logic          w_advance;
  logic          w_capture;
  logic          w_unsorted;
  logic [RW-1:0] w_rank_inc;

  assign w_rank_inc  = rank_q + RW'(1);
  assign w_last_beat = (state_q == SHIFT) && out_ready && (rank_q == LAST_RANK);
  assign w_advance   = (state_q == SHIFT) && out_ready && (rank_q != LAST_RANK);
  assign in_ready    = !rst && ((state_q == IDLE) || w_last_beat);
  assign w_capture   = in_ready && in_valid;

  // Equal neighbours are legal; only a strict rise between neighbours is an error.
  always_comb begin
    w_unsorted = 1'b0;
    for (int i = 0; i < N - 1; i++) begin
      if (in_data[i*WIDTH +: WIDTH] < in_data[(i+1)*WIDTH +: WIDTH]) begin
        w_unsorted = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rank_d  = rank_q;
    buf_d   = buf_q;
    data_d  = data_q;
    last_d  = last_q;
    if (w_capture) begin
      state_d = SHIFT;
      rank_d  = '0;
      for (int i = 0; i < N; i++) begin
        buf_d[i] = in_data[i*WIDTH +: WIDTH];
      end
      data_d = in_data[WIDTH-1:0];
      last_d = 1'b0;
    end else if (w_advance) begin
      rank_d = w_rank_inc;
      data_d = buf_q[w_rank_inc];
      last_d = (w_rank_inc == LAST_RANK);
    end else if (w_last_beat) begin
      state_d = IDLE;
      last_d  = 1'b0;
    end
  end

  // A capture in the same cycle as err_clear wins and restarts the count at 1.
  always_comb begin
    order_err_d = order_err_q;
    err_cnt_d   = err_cnt_q;
    if (w_capture && w_unsorted) begin
      order_err_d = 1'b1;
      if (err_clear) begin
        err_cnt_d = 8'd1;
      end else if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end else if (err_clear) begin
      order_err_d = 1'b0;
      err_cnt_d   = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rank_q  <= '0;
      for (int i = 0; i < N; i++) begin
        buf_q[i] <= '0;
      end
      data_q      <= '0;
      last_q      <= 1'b0;
      order_err_q <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      rank_q      <= rank_d;
      buf_q       <= buf_d;
      data_q      <= data_d;
      last_q      <= last_d;
      order_err_q <= order_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = !rst && (state_q == SHIFT);
  assign out_data  = data_q;
  assign out_rank  = rank_q;
  assign out_last  = !rst && last_q;
  assign order_err = order_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_sorted_vec_unloader.sv
// Directed self-checking bench for sorted_vec_unloader (WIDTH=10, N=4).
`default_nettype none

module tb_sorted_vec_unloader;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_data;
  logic [1:0]  out_rank;
  logic        out_last;
  logic        order_err;
  logic [7:0]  err_cnt;
  logic        err_clear;

  int checks = 0;
  int errors = 0;

  sorted_vec_unloader #(.WIDTH(10), .N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rank  (out_rank),
    .out_last  (out_last),
    .order_err (order_err),
    .err_cnt   (err_cnt),
    .err_clear (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [39:0] pack(input int e0, input int e1, input int e2, input int e3);
    return {10'(e3), 10'(e2), 10'(e1), 10'(e0)};
  endfunction

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_data = pack(1, 2, 3, 4); out_ready = 1'b1; err_clear = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 10'd0 || out_rank !== 2'd0 || out_last !== 1'b0)
      begin errors++; $display("FAIL post_reset_outputs: got data %0d rank %0d last %b expected 0 0 0", out_data, out_rank, out_last); end
    checks++; if (order_err !== 1'b0 || err_cnt !== 8'd0)
      begin errors++; $display("FAIL post_reset_err: got err %b cnt %0d expected 0 0", order_err, err_cnt); end
  endtask

  task automatic test_basic;
    int e[4] = '{1000, 700, 700, 3};
    @(negedge clk);
    in_valid = 1'b1; in_data = pack(1000, 700, 700, 3); out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %b expected 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 10'(e[i]) || out_rank !== 2'(i))
        begin errors++; $display("FAIL basic_beat%0d: got v%b %0d/%0d expected v1 %0d/%0d", i, out_valid, out_data, out_rank, e[i], i); end
      checks++; if (out_last !== (i == 3)) begin errors++; $display("FAIL basic_last%0d: got %b expected %b", i, out_last, (i == 3)); end
      checks++; if (order_err !== 1'b0) begin errors++; $display("FAIL basic_order_err%0d: got %b expected 0", i, order_err); end
    end
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_idle: got %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure;
    int e[4] = '{100, 50, 20, 5};
    logic pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int beat = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = pack(100, 50, 20, 5); out_ready = 1'b0;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = pat[j];
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 10'(e[beat]) || out_rank !== 2'(beat))
        begin errors++; $display("FAIL bp_cycle%0d: got v%b %0d/%0d expected v1 %0d/%0d", j, out_valid, out_data, out_rank, e[beat], beat); end
      if (pat[j]) beat++;
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_extra_beat: got valid %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    int e[8] = '{9, 8, 7, 6, 5, 4, 3, 2};
    @(negedge clk);
    in_valid = 1'b1; in_data = pack(9, 8, 7, 6); out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_data = pack(5, 4, 3, 2);
      in_valid = (i <= 3);
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 10'(e[i]) || out_rank !== 2'(i % 4))
        begin errors++; $display("FAIL b2b_beat%0d: got v%b %0d/%0d expected v1 %0d/%0d", i, out_valid, out_data, out_rank, e[i], i % 4); end
      checks++; if (in_ready !== (i == 3 || i == 7))
        begin errors++; $display("FAIL b2b_in_ready%0d: got %b expected %b", i, in_ready, (i == 3 || i == 7)); end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", out_valid); end
  endtask

  task automatic test_unsorted;
    int e[4] = '{3, 10, 2, 1};
    @(negedge clk);
    in_valid = 1'b1; in_data = pack(3, 10, 2, 1); out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 10'(e[i]))
        begin errors++; $display("FAIL unsorted_beat%0d: got v%b %0d expected v1 %0d", i, out_valid, out_data, e[i]); end
      if (i == 0) begin
        checks++; if (order_err !== 1'b1 || err_cnt !== 8'd1)
          begin errors++; $display("FAIL unsorted_flag: got err %b cnt %0d expected 1 1", order_err, err_cnt); end
      end
    end
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    #1;
    checks++; if (order_err !== 1'b0 || err_cnt !== 8'd0)
      begin errors++; $display("FAIL unsorted_clear: got err %b cnt %0d expected 0 0", order_err, err_cnt); end
  endtask

  task automatic test_saturation;
    // Captures land every 4 cycles (0, 4, ..., 1020): 256 unsorted vectors back to back.
    for (int c = 0; c <= 1024; c++) begin
      @(negedge clk);
      in_valid = (c <= 1020); in_data = pack(1, 5, 0, 0); out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (err_cnt !== 8'd255 || order_err !== 1'b1)
      begin errors++; $display("FAIL sat_count: got cnt %0d err %b expected 255 1", err_cnt, order_err); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sat_idle: got %b expected 0", out_valid); end
    @(negedge clk);
    in_valid = 1'b1; err_clear = 1'b1; in_data = pack(0, 7, 0, 0);
    @(negedge clk);
    in_valid = 1'b0; err_clear = 1'b0;
    #1;
    checks++; if (err_cnt !== 8'd1 || order_err !== 1'b1)
      begin errors++; $display("FAIL clear_priority: got cnt %0d err %b expected 1 1", err_cnt, order_err); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    in_valid = 1'b1; in_data = pack(40, 30, 20, 10); out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_data !== 10'd40) begin errors++; $display("FAIL mid_beat0: got %0d expected 40", out_data); end
    @(negedge clk);
    #1;
    checks++; if (out_data !== 10'd30 || out_rank !== 2'd1)
      begin errors++; $display("FAIL mid_beat1: got %0d/%0d expected 30/1", out_data, out_rank); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0)
      begin errors++; $display("FAIL mid_during_rst: got v%b r%b expected v0 r0", out_valid, in_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0)
        begin errors++; $display("FAIL mid_after_rst%0d: got valid %b data %0d expected valid 0", i, out_valid, out_data); end
    end
    @(negedge clk);
    in_valid = 1'b1; in_data = pack(8, 6, 4, 2);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 10'd8 || out_rank !== 2'd0)
      begin errors++; $display("FAIL mid_restart: got v%b %0d/%0d expected v1 8/0", out_valid, out_data, out_rank); end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; err_clear = 1'b0;
    test_reset;
    test_basic;
    test_backpressure;
    test_back_to_back;
    test_unsorted;
    test_saturation;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
